// File: rtl/hi_tx_pkg.sv
// Shared definitions for the HF reader-transmit front end: modulation depth
// encoding used by the mode request input and the coil driver mux.
package hi_tx_pkg;

  typedef enum logic [1:0] {
    MOD_FULL         = 2'd0,
    MOD_SHALLOW      = 2'd1,
    MOD_DEEP_SHALLOW = 2'd2,
    MOD_CW           = 2'd3
  } mod_mode_e;

endpackage

// File: rtl/hi_adc_avg.sv
// ADC sample strobe and block averager: sums 2^AVG_LOG2 consecutive samples
// and publishes the truncated mean; the window restarts without losing a sample.
module hi_adc_avg import hi_tx_pkg::*; #(
  parameter int ADC_DIV_LOG2 = 1,
  parameter int DATA_W       = 8,
  parameter int AVG_LOG2     = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADC_DIV_LOG2-1:0] i_div_nxt,
  input  logic [DATA_W-1:0]       i_adc_d,
  output logic [DATA_W-1:0]       o_avg_q
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((1 << AVG_LOG2) - 1);

  logic             w_strobe;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_avg_q;

  // Sample on the cycle the ADC divider bits wrap to zero.
  assign w_strobe = (i_div_nxt == '0);
  assign w_sum    = r_acc + ACC_W'(i_adc_d);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_cnt   <= CNT_LOAD;
      r_avg_q <= '0;
    end else if (w_strobe) begin
      if (r_cnt == '0) begin
        r_avg_q <= DATA_W'(w_sum >> AVG_LOG2);
        r_acc   <= '0;
        r_cnt   <= CNT_LOAD;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_avg_q = r_avg_q;

endmodule

// File: rtl/hi_read_tx_gen.sv
// HF reader-transmit front end: SSP clock/frame generation, MSB-first serial
// upload of averaged ADC values, and frame-aligned modulation depth selection.
module hi_read_tx_gen import hi_tx_pkg::*; #(
  parameter int SSP_DIV_LOG2 = 4,
  parameter int ADC_DIV_LOG2 = 1,
  parameter int DATA_W       = 8,
  parameter int FRAME_BITS   = 8,
  parameter int AVG_LOG2     = 0
) (
  input  logic              ck_1356meg,
  input  logic              reset,
  input  logic              ck_1356megb,
  input  logic [DATA_W-1:0] adc_d,
  input  logic [1:0]        mod_mode,
  input  logic              ssp_dout,
  output logic              adc_clk,
  output logic              ssp_clk,
  output logic              ssp_frame,
  output logic              ssp_din,
  output logic              pwr_hi,
  output logic              pwr_lo,
  output logic              pwr_oe1,
  output logic              pwr_oe2,
  output logic              pwr_oe3,
  output logic              pwr_oe4,
  output logic              dbg
);

  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [SSP_DIV_LOG2-1:0] DIV_HALF = {1'b1, {(SSP_DIV_LOG2-1){1'b0}}};
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  logic [SSP_DIV_LOG2-1:0] r_div_cnt;
  logic [SSP_DIV_LOG2-1:0] w_div_nxt;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic [DATA_W-1:0]       r_shift;
  logic [DATA_W-1:0]       w_avg_q;
  logic                    r_ssp_clk;
  logic                    r_adc_clk;
  logic                    r_ssp_din;
  logic                    r_ssp_frame;
  logic                    r_mod_q;
  mod_mode_e               r_mode_q;
  logic                    w_rise;
  logic                    w_bit_end;
  logic                    w_frame_end;

  assign w_div_nxt   = r_div_cnt + SSP_DIV_LOG2'(1);
  assign w_rise      = (w_div_nxt == DIV_HALF);
  assign w_bit_end   = (w_div_nxt == '0);
  assign w_frame_end = (r_bit_cnt == BIT_LAST);

  hi_adc_avg #(
    .ADC_DIV_LOG2 (ADC_DIV_LOG2),
    .DATA_W       (DATA_W),
    .AVG_LOG2     (AVG_LOG2)
  ) u_adc_avg (
    .i_clk     (ck_1356meg),
    .i_rst     (reset),
    .i_div_nxt (w_div_nxt[ADC_DIV_LOG2-1:0]),
    .i_adc_d   (adc_d),
    .o_avg_q   (w_avg_q)
  );

  // Clock outputs are registered from the next divider value so they stay
  // phase-aligned with r_div_cnt; ssp_din therefore moves with ssp_clk falling.
  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= BIT_LAST;
      r_shift     <= '0;
      r_ssp_clk   <= 1'b0;
      r_adc_clk   <= 1'b0;
      r_ssp_din   <= 1'b0;
      r_ssp_frame <= 1'b0;
      r_mod_q     <= 1'b0;
      r_mode_q    <= MOD_FULL;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_ssp_clk <= w_div_nxt[SSP_DIV_LOG2-1];
      r_adc_clk <= w_div_nxt[ADC_DIV_LOG2-1];
      if (w_rise) begin
        r_mod_q <= ssp_dout;
      end
      if (w_bit_end) begin
        if (w_frame_end) begin
          r_bit_cnt   <= '0;
          r_shift     <= w_avg_q << 1;
          r_ssp_din   <= w_avg_q[DATA_W-1];
          r_ssp_frame <= 1'b1;
          r_mode_q    <= mod_mode_e'(mod_mode);
        end else begin
          r_bit_cnt   <= r_bit_cnt + BIT_W'(1);
          r_ssp_din   <= r_shift[DATA_W-1];
          r_shift     <= r_shift << 1;
          r_ssp_frame <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    pwr_hi  = ck_1356megb;
    pwr_oe1 = 1'b0;
    pwr_oe2 = 1'b0;
    pwr_oe3 = 1'b0;
    pwr_oe4 = 1'b0;
    case (r_mode_q)
      MOD_FULL:         pwr_hi = ck_1356megb & ~r_mod_q;
      MOD_SHALLOW:      pwr_oe4 = r_mod_q;
      MOD_DEEP_SHALLOW: begin
        pwr_oe1 = r_mod_q;
        pwr_oe4 = r_mod_q;
      end
      default: ;
    endcase
  end

  assign pwr_lo    = 1'b0;
  assign adc_clk   = r_adc_clk;
  assign ssp_clk   = r_ssp_clk;
  assign ssp_frame = r_ssp_frame;
  assign ssp_din   = r_ssp_din;
  assign dbg       = r_ssp_frame;

endmodule

// File: tb/tb_hi_read_tx_gen.sv
// Scoreboard bench for hi_read_tx_gen: a time-based reference model predicts
// every cycle's outputs and every received SSP word from elapsed cycle count.
module tb_hi_read_tx_gen;

  localparam int SSP_DIV_LOG2 = 4;
  localparam int ADC_DIV_LOG2 = 1;
  localparam int DATA_W       = 8;
  localparam int FRAME_BITS   = 10;
  localparam int AVG_LOG2     = 2;

  localparam int P     = 1 << SSP_DIV_LOG2;
  localparam int HALF  = P / 2;
  localparam int AS    = 1 << ADC_DIV_LOG2;
  localparam int AVG_N = 1 << AVG_LOG2;
  localparam int FRAME = P * FRAME_BITS;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ckb = 1'b0;
  logic [DATA_W-1:0] adc_d = '0;
  logic [1:0]        mod_mode = 2'd0;
  logic              ssp_dout = 1'b0;
  logic adc_clk, ssp_clk, ssp_frame, ssp_din, pwr_hi, pwr_lo;
  logic pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg;

  always #5 clk = ~clk;

  hi_read_tx_gen #(
    .SSP_DIV_LOG2 (SSP_DIV_LOG2),
    .ADC_DIV_LOG2 (ADC_DIV_LOG2),
    .DATA_W       (DATA_W),
    .FRAME_BITS   (FRAME_BITS),
    .AVG_LOG2     (AVG_LOG2)
  ) dut (
    .ck_1356meg  (clk),
    .reset       (reset),
    .ck_1356megb (ckb),
    .adc_d       (adc_d),
    .mod_mode    (mod_mode),
    .ssp_dout    (ssp_dout),
    .adc_clk     (adc_clk),
    .ssp_clk     (ssp_clk),
    .ssp_frame   (ssp_frame),
    .ssp_din     (ssp_din),
    .pwr_hi      (pwr_hi),
    .pwr_lo      (pwr_lo),
    .pwr_oe1     (pwr_oe1),
    .pwr_oe2     (pwr_oe2),
    .pwr_oe3     (pwr_oe3),
    .pwr_oe4     (pwr_oe4),
    .dbg         (dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: t = clock edges since reset release.
  typedef struct packed {
    logic       sclk;
    logic       aclk;
    logic       din;
    logic       frm;
    logic       mq;
    logic [1:0] md;
  } exp_t;

  exp_t                  exp_cyc[$];
  logic [FRAME_BITS-1:0] exp_word[$];
  int                    samp[$];
  int                    t = 0;
  logic                  modq = 1'b0;
  logic [1:0]            mode = 2'd0;
  logic [DATA_W-1:0]     loaded = '0;

  // Mean of the last complete averaging window as of edge x.
  function automatic int avg_after(input int x);
    int w;
    int s;
    w = x / (AS * AVG_N) - 1;
    if (w < 0) return 0;
    s = 0;
    for (int k = 0; k < AVG_N; k++) s += samp[w * AVG_N + k];
    return s / AVG_N;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   b;
    if (!reset) begin
      t++;
      if (t % AS == 0) samp.push_back(int'(adc_d));
      if (t >= P && (t - P) % FRAME == 0) begin
        loaded = DATA_W'(avg_after(t - 1));
        exp_word.push_back({loaded, {(FRAME_BITS - DATA_W){1'b0}}});
        mode = mod_mode;
      end
      if (t % P == HALF) modq = ssp_dout;
      e.sclk = ((t % P) >= HALF);
      e.aclk = ((t % AS) >= AS / 2);
      e.din  = 1'b0;
      e.frm  = 1'b0;
      if (t >= P) begin
        b = ((t - P) / P) % FRAME_BITS;
        e.frm = (b == 0);
        if (b < DATA_W) e.din = loaded[DATA_W-1-b];
      end
      e.mq = modq;
      e.md = mode;
      exp_cyc.push_back(e);
    end
  end

  // Monitor: per-cycle compare plus an ARM-side receiver sampling on ssp_clk rise.
  logic                  prev_sclk = 1'b0;
  logic                  rx_on = 1'b0;
  int                    rx_n = 0;
  int                    frames_rx = 0;
  logic [FRAME_BITS-1:0] rx_word = '0;

  always @(negedge clk) begin
    exp_t       e;
    logic [5:0] xd;
    if (reset) begin
      chk("reset_ssp", {11'd0, adc_clk, ssp_clk, ssp_frame, ssp_din, dbg}, 16'd0);
      chk("reset_drv", {10'd0, pwr_hi, pwr_lo, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4},
          {10'd0, ckb, 5'b00000});
      rx_on = 1'b0;
      rx_n = 0;
      prev_sclk = 1'b0;
    end else if (exp_cyc.size() == 0) begin
      chk("exp_queue", 16'(exp_cyc.size()), 16'd1);
    end else begin
      e = exp_cyc.pop_front();
      chk("ssp", {11'd0, ssp_clk, adc_clk, ssp_din, ssp_frame, dbg},
          {11'd0, e.sclk, e.aclk, e.din, e.frm, e.frm});
      case (e.md)
        2'd0:    xd = {ckb & ~e.mq, 5'b00000};
        2'd1:    xd = {ckb, 4'b0000, e.mq};
        2'd2:    xd = {ckb, 1'b0, e.mq, 2'b00, e.mq};
        default: xd = {ckb, 5'b00000};
      endcase
      chk("drv", {10'd0, pwr_hi, pwr_lo, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4}, {10'd0, xd});
      if (ssp_clk && !prev_sclk) begin
        if (ssp_frame) begin
          rx_on = 1'b1;
          rx_n = 1;
          rx_word = FRAME_BITS'(ssp_din);
        end else if (rx_on) begin
          rx_word = {rx_word[FRAME_BITS-2:0], ssp_din};
          rx_n++;
        end
        if (rx_on && rx_n == FRAME_BITS) begin
          rx_on = 1'b0;
          frames_rx++;
          if (exp_word.size() == 0) chk("word_queue", 16'(exp_word.size()), 16'd1);
          else chk("frame_word", 16'(rx_word), 16'(exp_word.pop_front()));
        end
      end
      prev_sclk = ssp_clk;
    end
  end

  // Stimulus
  int adc_sel = 0;
  bit rand_mode = 1'b0;
  int pat_a[4] = '{10, 20, 30, 40};
  int pat_b[4] = '{3, 3, 3, 4};

  task automatic step(input int n);
    int s;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      ckb = 1'($urandom);
      ssp_dout = 1'($urandom);
      if (rand_mode && $urandom_range(0, 39) == 0) mod_mode = 2'($urandom);
      case (adc_sel)
        0: adc_d = DATA_W'($urandom);
        1, 2: begin
          if ((t + 1) % AS == 0) begin
            s = ((t + 1) / AS - 1) % AVG_N;
            adc_d = DATA_W'((adc_sel == 1) ? pat_a[s] : pat_b[s]);
          end
        end
        default: adc_d = '0;
      endcase
    end
  endtask

  task automatic wait_bit(input int bit_i, input int min_ph);
    int k;
    k = 0;
    while (!(t >= P && ((t - P) % FRAME) / P == bit_i && (t % P) >= min_ph) && k < 2 * FRAME) begin
      step(1);
      k++;
    end
    if (k >= 2 * FRAME) chk("wait_bit_timeout", 16'(k), 16'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    adc_sel = 3;
    step(3);
    @(negedge clk);
    #1 reset = 1'b0;
    step(180);

    adc_sel = 0;
    rand_mode = 1'b1;
    step(6 * FRAME);

    rand_mode = 1'b0;
    mod_mode = 2'd0;
    wait_bit(3, 0);
    mod_mode = 2'd1;
    step(2 * FRAME);
    mod_mode = 2'd3;
    step(2 * FRAME);

    mod_mode = 2'd2;
    adc_sel = 1;
    step(3 * FRAME);
    adc_sel = 2;
    step(3 * FRAME);

    adc_sel = 0;
    mod_mode = 2'd0;
    wait_bit(5, HALF + 2);
    @(negedge clk);
    #1 reset = 1'b1;
    t = 0;
    samp.delete();
    modq = 1'b0;
    mode = 2'd0;
    loaded = '0;
    exp_cyc.delete();
    exp_word.delete();
    #1;
    chk("async_reset_ssp", {11'd0, adc_clk, ssp_clk, ssp_frame, ssp_din, dbg}, 16'd0);
    chk("async_reset_drv", {10'd0, pwr_hi, pwr_lo, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4},
        {10'd0, ckb, 5'b00000});
    adc_sel = 3;
    step(2);
    @(negedge clk);
    #1 reset = 1'b0;
    step(400);
    adc_sel = 0;
    mod_mode = 2'd1;
    step(2 * FRAME);

    chk("frames_rx_min", 16'(frames_rx >= 15), 16'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
